// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: bundles the fetch-side push bus and the decode-side
// pop bus of the instruction queue.
//   master : fetch/decoder side. It drives push_* and dec_accept and
//            observes out_*, stall and count.
//   slave  : the queue itself.
// count is log2(DEPTH)+1 bits wide so it can hold DEPTH.
interface ifetch_queue_if #(
  parameter int DEPTH = 8
) ();
  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_valid;
  logic [1:0]    push_mask;
  logic [31:0]   push_pc0;
  logic [31:0]   push_pc1;
  logic [31:0]   push_inst0;
  logic [31:0]   push_inst1;
  logic [1:0]    dec_accept;
  logic [1:0]    out_valid;
  logic [31:0]   out_pc0;
  logic [31:0]   out_pc1;
  logic [31:0]   out_inst0;
  logic [31:0]   out_inst1;
  logic          stall;
  logic [CW-1:0] count;

  modport master (
    output push_valid, push_mask, push_pc0, push_pc1, push_inst0, push_inst1,
    output dec_accept,
    input  out_valid, out_pc0, out_pc1, out_inst0, out_inst1, stall, count
  );

  modport slave (
    input  push_valid, push_mask, push_pc0, push_pc1, push_inst0, push_inst1,
    input  dec_accept,
    output out_valid, out_pc0, out_pc1, out_inst0, out_inst1, stall, count
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: dual-wide first-word-fall-through instruction queue that sits
// between fetch and the two decoders.
//   clk, rst : clock and synchronous active-high reset
//   flush    : discard every queued entry (redirect, exception, ertn)
//   q        : ifetch_queue_if.slave
//              push_valid/push_mask/push_pc*/push_inst* : a fetch pair (mask 01 or 11)
//              dec_accept : thermometer pop request from the decoders
//              out_*      : head and head+1 entries, valid from occupancy
//              stall      : fewer than two free entries, drives the PC pause
//              count      : occupancy
// All outputs come from registered state, so nothing here is combinational
// from push_* or dec_accept to stall.
module ifetch_queue #(
  parameter int DEPTH         = 8,
  parameter int DECODER_WIDTH = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  ifetch_queue_if.slave  q
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [PW-1:0]   head;
  logic [PW-1:0]   tail;
  logic [CW-1:0]   count_r;

  logic            stall_w;
  logic [DECODER_WIDTH-1:0]         rd_vld;
  logic [DECODER_WIDTH-1:0][31:0]   rd_pc;
  logic [DECODER_WIDTH-1:0][31:0]   rd_inst;

  // Read side: out slot s shows entry head+s and is valid once the queue
  // holds more than s entries.
  for (genvar s = 0; s < DECODER_WIDTH; s++) begin : g_rd
    logic [PW-1:0] idx;
    assign idx        = head + PW'(s);
    assign rd_vld[s]  = (count_r > CW'(s));
    assign rd_pc[s]   = mem[idx].pc;
    assign rd_inst[s] = mem[idx].inst;
  end

  assign stall_w     = (count_r > CW'(DEPTH - 2));
  assign q.stall     = stall_w;
  assign q.count     = count_r;
  assign q.out_valid = rd_vld[1:0];
  assign q.out_pc0   = rd_pc[0];
  assign q.out_pc1   = rd_pc[1];
  assign q.out_inst0 = rd_inst[0];
  assign q.out_inst1 = rd_inst[1];

  // Push: slot 0 must be present for anything to be written, so masks 10
  // and 00 write nothing. A pair offered while stalled is simply dropped.
  logic          push_ok;
  logic          wr0;
  logic          wr1;
  logic [1:0]    npush;
  logic [PW-1:0] tail_p1;

  assign push_ok = q.push_valid & ~stall_w & ~flush;
  assign wr0     = push_ok & q.push_mask[0];
  assign wr1     = wr0 & q.push_mask[1];
  assign npush   = {1'b0, wr0} + {1'b0, wr1};
  assign tail_p1 = tail + PW'(1);

  // Pop: slot 1 only counts if slot 0 is consumed in the same cycle.
  logic       pop0;
  logic       pop1;
  logic [1:0] npop;

  assign pop0 = q.dec_accept[0] & rd_vld[0];
  assign pop1 = pop0 & q.dec_accept[1] & rd_vld[1];
  assign npop = {1'b0, pop0} + {1'b0, pop1};

  // Storage carries no reset; entries beyond count are never shown as valid.
  // Since a push needs two free entries, writes never land on head/head+1
  // while they are still occupied.
  always_ff @(posedge clk) begin
    if (wr0) mem[tail]    <= '{pc: q.push_pc0, inst: q.push_inst0};
    if (wr1) mem[tail_p1] <= '{pc: q.push_pc1, inst: q.push_inst1};
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      head    <= '0;
      tail    <= '0;
      count_r <= '0;
    end else begin
      head    <= head + PW'(npop);
      tail    <= tail + PW'(npush);
      count_r <= count_r + CW'(npush) - CW'(npop);
    end
  end
endmodule
